// File: rtl/linear_regression_calculator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : linear_regression_calculator_pkg
// Purpose  : shared widths, state encoding and Q10.10 saturation helper
// Revision : 1.0
// ============================================================================
package linear_regression_calculator_pkg;

    localparam int Q_W       = 20;
    localparam int FRAC_W    = 10;
    localparam int SUM_W     = 30;
    localparam int SQ_W      = 50;
    localparam int DIV_W     = 64;
    localparam int DIV_ITERS = 64;

    localparam logic signed [DIV_W-1:0] Q_MAX = 64'sd524287;
    localparam logic signed [DIV_W-1:0] Q_MIN = -64'sd524288;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_FORM1 = 3'd3,
        ST_DIV1  = 3'd4,
        ST_FORM0 = 3'd5,
        ST_DIV0  = 3'd6,
        ST_CHECK = 3'd7
    } state_t;

    function automatic logic signed [Q_W-1:0] sat_q(input logic signed [DIV_W-1:0] v);
        if (v > Q_MAX)
            return Q_MAX[Q_W-1:0];
        else if (v < Q_MIN)
            return Q_MIN[Q_W-1:0];
        else
            return v[Q_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/coefficient_calculator.sv
`default_nettype none
// ============================================================================
// Module   : coefficient_calculator
// Purpose  : accumulates the first replay pass and solves for slope/intercept
// Revision : 1.0
// ============================================================================
module coefficient_calculator
    import linear_regression_calculator_pkg::*;
#(
    parameter int N = 150
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  coef_en,
    input  logic signed [Q_W-1:0] x,
    input  logic signed [Q_W-1:0] y,
    output logic signed [Q_W-1:0] b_0,
    output logic signed [Q_W-1:0] b_1,
    output logic                  err_en
);

    localparam int                      CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N - 1);
    localparam logic signed [DIV_W-1:0] N_S      = DIV_W'(N);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [SUM_W-1:0] sx, sy;
    logic signed [SQ_W-1:0]  sxx, sxy;
    logic signed [Q_W-1:0]   b1_q;
    logic                    den_zero;

    logic signed [2*Q_W-1:0] xx, xy;
    logic signed [DIV_W-1:0] sx_w, sy_w, num1, den, num0;
    logic signed [DIV_W-1:0] dividend, divisor, quo;
    logic                    acc_en, div_start, div_done;

    assign xx     = x * x;
    assign xy     = x * y;
    assign acc_en = ((state == ST_IDLE) && coef_en) || (state == ST_ACCUM);

    assign sx_w = DIV_W'(sx);
    assign sy_w = DIV_W'(sy);
    assign num1 = N_S * DIV_W'(sxy) - sx_w * sy_w;
    assign den  = N_S * DIV_W'(sxx) - sx_w * sx_w;
    assign num0 = (sy_w <<< FRAC_W) - DIV_W'(b1_q) * sx_w;

    assign div_start = (state == ST_FORM1) || (state == ST_FORM0);
    assign dividend  = (state == ST_FORM1) ? (num1 <<< FRAC_W) : num0;
    assign divisor   = (state == ST_FORM1) ? den : (N_S <<< FRAC_W);

    seq_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quo),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sx       <= '0;
            sy       <= '0;
            sxx      <= '0;
            sxy      <= '0;
            b1_q     <= '0;
            den_zero <= 1'b0;
            b_0      <= '0;
            b_1      <= '0;
            err_en   <= 1'b0;
        end else begin
            if (acc_en) begin
                sx  <= sx + SUM_W'(x);
                sy  <= sy + SUM_W'(y);
                sxx <= sxx + SQ_W'(xx);
                sxy <= sxy + SQ_W'(xy);
            end
            case (state)
                ST_IDLE: begin
                    if (coef_en) begin
                        cnt   <= CNT_W'(1);
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (cnt == LAST_CNT) state <= ST_FORM1;
                    else                 cnt   <= cnt + 1'b1;
                end
                ST_FORM1: begin
                    den_zero <= (den == '0);
                    state    <= ST_DIV1;
                end
                ST_DIV1: begin
                    // identical x values leave the slope undefined; force it flat
                    if (div_done) begin
                        b1_q  <= den_zero ? '0 : sat_q(quo);
                        state <= ST_FORM0;
                    end
                end
                ST_FORM0: state <= ST_DIV0;
                ST_DIV0: begin
                    if (div_done) begin
                        b_0    <= sat_q(quo);
                        b_1    <= b1_q;
                        err_en <= 1'b1;
                        state  <= ST_CHECK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_loader.sv
`default_nettype none
// ============================================================================
// Module   : data_loader
// Purpose  : captures N sample pairs, then replays them forever with wrap
// Revision : 1.0
// ============================================================================
module data_loader
    import linear_regression_calculator_pkg::*;
#(
    parameter int N = 150
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [Q_W-1:0] x_in,
    input  logic signed [Q_W-1:0] y_in,
    output logic signed [Q_W-1:0] x,
    output logic signed [Q_W-1:0] y,
    output logic                  coef_en
);

    localparam int              IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic signed [Q_W-1:0] mem_x [N];
    logic signed [Q_W-1:0] mem_y [N];
    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  wr_en;

    // idx is still 0 in IDLE, so it doubles as the write address for sample 0
    assign wr_en = ((state == ST_IDLE) && start) || (state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_x[idx] <= x_in;
            mem_y[idx] <= y_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            x       <= '0;
            y       <= '0;
            coef_en <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= IDX_W'(1);
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= ST_ACCUM;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // ACCUM marks the first replay pass, CHECK every later one
                    x       <= mem_x[idx];
                    y       <= mem_y[idx];
                    coef_en <= (state == ST_ACCUM);
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= ST_CHECK;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/error_checker.sv
`default_nettype none
// ============================================================================
// Module   : error_checker
// Purpose  : registered residual y - (b_0 + b_1*x) in saturated Q10.10
// Revision : 1.0
// ============================================================================
module error_checker
    import linear_regression_calculator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  err_en,
    input  logic signed [Q_W-1:0] x,
    input  logic signed [Q_W-1:0] y,
    input  logic signed [Q_W-1:0] b_0,
    input  logic signed [Q_W-1:0] b_1,
    output logic signed [Q_W-1:0] error
);

    logic signed [2*Q_W-1:0] prod;
    logic signed [DIV_W-1:0] resid;

    assign prod  = b_1 * x;
    assign resid = DIV_W'(y) - (DIV_W'(b_0) + DIV_W'(prod >>> FRAC_W));

    always_ff @(posedge clk) begin
        if (reset) error <= '0;
        else       error <= err_en ? sat_q(resid) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : signed restoring radix-2 divider, truncating toward zero
// Revision : 1.0
// ============================================================================
module seq_divider
    import linear_regression_calculator_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [DIV_W-1:0] dividend,
    input  logic signed [DIV_W-1:0] divisor,
    output logic signed [DIV_W-1:0] quotient,
    output logic                    done
);

    function automatic logic [DIV_W-1:0] magnitude(input logic signed [DIV_W-1:0] v);
        return v[DIV_W-1] ? -v : v;
    endfunction

    logic [DIV_W-1:0] rem, quo, dsr;
    logic             neg, busy;
    logic [6:0]       cnt;
    logic [DIV_W-1:0] step_rem, step_quo, step_dsr, nxt_rem, nxt_quo;
    logic [DIV_W:0]   trial, diff;
    logic             ge;

    // the start edge already performs the first iteration on the fresh operands
    always_comb begin
        step_dsr = start ? magnitude(divisor)  : dsr;
        step_rem = start ? '0                  : rem;
        step_quo = start ? magnitude(dividend) : quo;
        trial    = {step_rem, step_quo[DIV_W-1]};
        diff     = trial - {1'b0, step_dsr};
        ge       = (trial >= {1'b0, step_dsr});
        nxt_rem  = ge ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
        nxt_quo  = {step_quo[DIV_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem  <= '0;
            quo  <= '0;
            dsr  <= '0;
            neg  <= 1'b0;
            busy <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= nxt_rem;
                quo  <= nxt_quo;
                dsr  <= step_dsr;
                neg  <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
                busy <= 1'b1;
                cnt  <= 7'd1;
            end else if (busy) begin
                rem <= nxt_rem;
                quo <= nxt_quo;
                cnt <= cnt + 7'd1;
                if (cnt == 7'(DIV_ITERS - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = neg ? -quo : quo;

endmodule
`default_nettype wire

// File: rtl/linear_regression_calculator.sv
`default_nettype none
// ============================================================================
// Module   : linear_regression_calculator
// Purpose  : streaming least-squares line fit with per-sample residual output
// Revision : 1.0
// ============================================================================
module linear_regression_calculator
    import linear_regression_calculator_pkg::*;
#(
    parameter int N = 150
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [Q_W-1:0] x_Bus,
    input  logic signed [Q_W-1:0] y_Bus,
    output logic signed [Q_W-1:0] x,
    output logic signed [Q_W-1:0] y,
    output logic                  coef_en,
    output logic                  err_en,
    output logic signed [Q_W-1:0] b_0,
    output logic signed [Q_W-1:0] b_1,
    output logic signed [Q_W-1:0] error
);

    data_loader #(.N(N)) u_loader (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x_in    (x_Bus),
        .y_in    (y_Bus),
        .x       (x),
        .y       (y),
        .coef_en (coef_en)
    );

    coefficient_calculator #(.N(N)) u_coef (
        .clk     (clk),
        .reset   (reset),
        .coef_en (coef_en),
        .x       (x),
        .y       (y),
        .b_0     (b_0),
        .b_1     (b_1),
        .err_en  (err_en)
    );

    error_checker u_err (
        .clk    (clk),
        .reset  (reset),
        .err_en (err_en),
        .x      (x),
        .y      (y),
        .b_0    (b_0),
        .b_1    (b_1),
        .error  (error)
    );

endmodule
`default_nettype wire

// File: tb/tb_linear_regression_calculator.sv
`default_nettype none
// ============================================================================
// Module   : tb_linear_regression_calculator
// Purpose  : directed self-checking bench for the regression datapath
// Revision : 1.0
// ============================================================================
module tb_linear_regression_calculator;

    localparam int N   = 150;
    localparam int LAT = N + 130;

    logic              clk = 1'b0;
    logic              reset, start;
    logic signed [19:0] x_Bus, y_Bus;
    logic signed [19:0] x, y, b_0, b_1, error;
    logic              coef_en, err_en;

    int checks = 0;
    int errors = 0;

    logic signed [19:0] xs [N];
    logic signed [19:0] ys [N];
    logic signed [19:0] es [N];
    logic [19:0]        exp_b0, exp_b1;
    logic [19:0]        sb [$];

    linear_regression_calculator #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x_Bus   (x_Bus),
        .y_Bus   (y_Bus),
        .x       (x),
        .y       (y),
        .coef_en (coef_en),
        .err_en  (err_en),
        .b_0     (b_0),
        .b_1     (b_1),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_x"},       x,              20'h0);
        check({tag, "_y"},       y,              20'h0);
        check({tag, "_b0"},      b_0,            20'h0);
        check({tag, "_b1"},      b_1,            20'h0);
        check({tag, "_error"},   error,          20'h0);
        check({tag, "_coef_en"}, 20'(coef_en),   20'h0);
        check({tag, "_err_en"},  20'(err_en),    20'h0);
    endtask

    task automatic set_case(input int k);
        for (int i = 0; i < N; i++) begin
            es[i] = '0;
            case (k)
                1: begin xs[i] = 20'(i * 1024); ys[i] = 20'(i * 2048 + 1024); end
                2: begin xs[i] = 20'(i * 1024); ys[i] = 20'(3072); end
                3: begin xs[i] = 20'(5120);     ys[i] = 20'(i * 1024);
                         es[i] = 20'(i * 1024 - 76288); end
                default: begin xs[i] = 20'(i * 256); ys[i] = 20'(10240 - i * 128); end
            endcase
        end
        case (k)
            1:       begin exp_b1 = 20'h00800; exp_b0 = 20'h00400; end
            2:       begin exp_b1 = 20'h00000; exp_b0 = 20'h00C00; end
            3:       begin exp_b1 = 20'h00000; exp_b0 = 20'h12A00; end
            default: begin exp_b1 = 20'hFFE00; exp_b0 = 20'h02800; end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
    endtask

    // abort_c > 0 pulls reset at that cycle after coef_en rises
    task automatic run(input int k, input bit hold_start, input int abort_c);
        int w;
        logic [19:0] e;
        set_case(k);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            start = (i == 0) || hold_start;
            x_Bus = xs[i];
            y_Bus = ys[i];
        end
        @(negedge clk);
        start = hold_start;
        x_Bus = 20'h12345;
        y_Bus = 20'h54321;
        check("coef_en_early", 20'(coef_en), 20'h0);
        w = 0;
        @(negedge clk);
        while (!coef_en && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("coef_rise_delay", 20'(w), 20'h0);
        for (int c = 0; c <= LAT + N + 20; c++) begin
            if (c > 0) @(negedge clk);
            if (abort_c > 0 && c == abort_c) begin
                reset = 1'b1;
                @(negedge clk);
                check_idle("abort");
                @(negedge clk);
                check_idle("abort_hold");
                reset = 1'b0;
                sb.delete();
                return;
            end
            check("coef_en", 20'(coef_en), 20'(c < N));
            check("err_en",  20'(err_en),  20'(c >= LAT));
            check("replay_x", x, xs[c % N]);
            check("replay_y", y, ys[c % N]);
            if (c == LAT - 1) check("b1_before_valid", b_1, 20'h0);
            if (c == LAT) begin
                check("b_1", b_1, exp_b1);
                check("b_0", b_0, exp_b0);
            end
            if (c > LAT) begin
                e = sb.pop_front();
                check("error", error, e);
            end
            if (c >= LAT) sb.push_back(es[c % N]);
        end
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_Bus = '0;
        y_Bus = '0;
        repeat (2) @(negedge clk);
        check_idle("por");
        reset = 1'b0;

        x_Bus = 20'h0ABCD;
        y_Bus = 20'h01234;
        repeat (20) @(negedge clk);
        check_idle("no_start");

        run(1, 1'b0, 0);
        do_reset();
        run(2, 1'b1, 0);
        do_reset();
        run(3, 1'b0, 0);
        do_reset();
        run(4, 1'b0, 0);
        do_reset();
        run(1, 1'b0, N + 20);
        run(1, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
